uart_slip_framer: RTL and testbench

//  Upstream stage of the UART transmitter: SLIP-encodes (RFC 1055) byte packets arriving on AXI-Stream.

---
 rtl/uart_slip_framer.sv | 210 +++++++++++++++++++++
 tb/tb_uart_slip_framer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_slip_framer.sv
// SLIP (RFC 1055) framer feeding the UART transmitter. It encodes an AXI-Stream byte packet,
// optionally appends a stuffed XOR checksum, and emits one encoded byte per output beat.
module uart_slip_framer #(
   parameter bit LEADING_END = 1'b1,
   parameter bit CHECKSUM_EN = 1'b1
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic [7:0]  s_axis_tdata,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   input  logic        s_axis_tlast,
   output logic [15:0] m_axis_tdata,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic [31:0] frame_count
);

   localparam logic [7:0] SLIP_END = 8'hC0;
   localparam logic [7:0] SLIP_ESC = 8'hDB;
   localparam logic [7:0] ESC_END  = 8'hDC;
   localparam logic [7:0] ESC_ESC  = 8'hDD;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SOF       = 3'd1,
      ST_DATA      = 3'd2,
      ST_ESC2      = 3'd3,
      ST_CSUM      = 3'd4,
      ST_CSUM_ESC2 = 3'd5,
      ST_EOF       = 3'd6
   } state_t;

   function automatic logic f_needs_esc(input logic [7:0] b);
      return (b == SLIP_END) || (b == SLIP_ESC);
   endfunction

   function automatic logic [7:0] f_esc_code(input logic [7:0] b);
      return (b == SLIP_END) ? ESC_END : ESC_ESC;
   endfunction

   state_t      r_state;
   logic [7:0]  r_csum;
   logic [7:0]  r_pend;
   logic        r_last;
   logic [7:0]  r_tdata;
   logic        r_tvalid;
   logic        r_is_eof;
   logic [31:0] r_frame_count;

   state_t      w_state_nxt;
   state_t      w_tail_state;
   logic [7:0]  w_csum_nxt;
   logic [7:0]  w_pend_nxt;
   logic        w_last_nxt;
   logic        w_load;
   logic [7:0]  w_load_data;
   logic        w_load_eof;
   logic        w_load_ok;
   logic        w_in_hs;

   assign w_load_ok     = !r_tvalid || m_axis_tready;
   assign s_axis_tready = w_load_ok && (r_state == ST_DATA);
   assign w_in_hs       = s_axis_tvalid && s_axis_tready;
   assign w_tail_state  = CHECKSUM_EN ? ST_CSUM : ST_EOF;

   assign m_axis_tdata  = {8'h00, r_tdata};
   assign m_axis_tvalid = r_tvalid;
   assign frame_count   = r_frame_count;

   // Next-state and output-load decode; every emitted byte passes through w_load_data.
   always_comb begin
      w_state_nxt = r_state;
      w_csum_nxt  = r_csum;
      w_pend_nxt  = r_pend;
      w_last_nxt  = r_last;
      w_load      = 1'b0;
      w_load_data = 8'h00;
      w_load_eof  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (s_axis_tvalid) begin
               w_csum_nxt  = 8'h00;
               w_state_nxt = LEADING_END ? ST_SOF : ST_DATA;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_SOF: begin
            if (w_load_ok) begin
               w_load      = 1'b1;
               w_load_data = SLIP_END;
               w_state_nxt = ST_DATA;
            end else begin
               w_state_nxt = ST_SOF;
            end
         end
         ST_DATA: begin
            if (w_in_hs) begin
               w_csum_nxt = r_csum ^ s_axis_tdata;
               w_last_nxt = s_axis_tlast;
               w_load     = 1'b1;
               if (f_needs_esc(s_axis_tdata)) begin
                  w_load_data = SLIP_ESC;
                  w_pend_nxt  = f_esc_code(s_axis_tdata);
                  w_state_nxt = ST_ESC2;
               end else begin
                  w_load_data = s_axis_tdata;
                  w_state_nxt = s_axis_tlast ? w_tail_state : ST_DATA;
               end
            end else begin
               w_state_nxt = ST_DATA;
            end
         end
         ST_ESC2: begin
            // tlast was captured with the escaped byte, so the frame still closes here
            if (w_load_ok) begin
               w_load      = 1'b1;
               w_load_data = r_pend;
               w_state_nxt = r_last ? w_tail_state : ST_DATA;
            end else begin
               w_state_nxt = ST_ESC2;
            end
         end
         ST_CSUM: begin
            if (w_load_ok) begin
               w_load = 1'b1;
               if (f_needs_esc(r_csum)) begin
                  w_load_data = SLIP_ESC;
                  w_pend_nxt  = f_esc_code(r_csum);
                  w_state_nxt = ST_CSUM_ESC2;
               end else begin
                  w_load_data = r_csum;
                  w_state_nxt = ST_EOF;
               end
            end else begin
               w_state_nxt = ST_CSUM;
            end
         end
         ST_CSUM_ESC2: begin
            if (w_load_ok) begin
               w_load      = 1'b1;
               w_load_data = r_pend;
               w_state_nxt = ST_EOF;
            end else begin
               w_state_nxt = ST_CSUM_ESC2;
            end
         end
         ST_EOF: begin
            if (w_load_ok) begin
               w_load      = 1'b1;
               w_load_data = SLIP_END;
               w_load_eof  = 1'b1;
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_EOF;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // FSM state and per-frame context (checksum, pending escape code, latched tlast).
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state <= ST_IDLE;
         r_csum  <= 8'h00;
         r_pend  <= 8'h00;
         r_last  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_csum  <= w_csum_nxt;
         r_pend  <= w_pend_nxt;
         r_last  <= w_last_nxt;
      end
   end

   // Output register; r_is_eof tags the trailing END so only its handshake counts a frame.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_tdata  <= 8'h00;
         r_tvalid <= 1'b0;
         r_is_eof <= 1'b0;
      end else if (w_load) begin
         r_tdata  <= w_load_data;
         r_tvalid <= 1'b1;
         r_is_eof <= w_load_eof;
      end else if (m_axis_tready) begin
         r_tvalid <= 1'b0;
         r_is_eof <= 1'b0;
      end else begin
         r_tvalid <= r_tvalid;
         r_is_eof <= r_is_eof;
      end
   end

   // Completed-frame counter, wrapping naturally at 2^32.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_frame_count <= 32'd0;
      end else if (r_tvalid && m_axis_tready && r_is_eof) begin
         r_frame_count <= r_frame_count + 32'd1;
      end else begin
         r_frame_count <= r_frame_count;
      end
   end

endmodule

// File: tb/tb_uart_slip_framer.sv
// Directed bench for uart_slip_framer: table of frames with hand-encoded output streams for two
// parameter sets, plus random back-pressure, and a mid-frame reset sequence.
module tb_uart_slip_framer;

   logic        clk;
   logic        rst_n;
   logic [7:0]  s_tdata;
   logic        s_tvalid;
   logic        s_tlast;
   logic        m_tready;
   logic        sel;
   logic        rnd_mode;

   logic        a_s_tready, b_s_tready;
   logic [15:0] a_m_tdata, b_m_tdata;
   logic        a_m_tvalid, b_m_tvalid;
   logic [31:0] a_fc, b_fc;

   logic        w_s_tready;
   logic [15:0] w_m_tdata;
   logic        w_m_tvalid;
   logic [31:0] w_fc;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   logic [7:0] beat_q[$];
   int         cyc_q[$];

   uart_slip_framer #(.LEADING_END(1'b1), .CHECKSUM_EN(1'b1)) dut_a (
      .aclk(clk), .aresetn(rst_n),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid && !sel), .s_axis_tready(a_s_tready),
      .s_axis_tlast(s_tlast),
      .m_axis_tdata(a_m_tdata), .m_axis_tvalid(a_m_tvalid), .m_axis_tready(m_tready),
      .frame_count(a_fc)
   );

   uart_slip_framer #(.LEADING_END(1'b0), .CHECKSUM_EN(1'b0)) dut_b (
      .aclk(clk), .aresetn(rst_n),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid && sel), .s_axis_tready(b_s_tready),
      .s_axis_tlast(s_tlast),
      .m_axis_tdata(b_m_tdata), .m_axis_tvalid(b_m_tvalid), .m_axis_tready(m_tready),
      .frame_count(b_fc)
   );

   assign w_s_tready = sel ? b_s_tready : a_s_tready;
   assign w_m_tdata  = sel ? b_m_tdata  : a_m_tdata;
   assign w_m_tvalid = sel ? b_m_tvalid : a_m_tvalid;
   assign w_fc       = sel ? b_fc       : a_fc;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [0:3][7:0] din;
      int              n_in;
      logic [0:7][7:0] dout;
      int              n_out;
      int              stalls;
      int              fc;
      logic            dut_b;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Downstream ready: always ready unless the random back-pressure phase is active.
   initial begin
      forever begin
         @(negedge clk);
         m_tready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Beat monitor: records handshaken beats and checks stability while stalled.
   initial begin
      logic       prev_stall;
      logic [7:0] prev_data;
      prev_stall = 1'b0;
      prev_data  = 8'h00;
      forever begin
         @(negedge clk);
         #3;
         cyc++;
         if (!rst_n) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall)
               check("stall_stable", 32'({w_m_tvalid, w_m_tdata[7:0]}), 32'({1'b1, prev_data}));
            if (w_m_tvalid && m_tready) begin
               check("upper_zero", 32'(w_m_tdata[15:8]), 32'd0);
               beat_q.push_back(w_m_tdata[7:0]);
               cyc_q.push_back(cyc);
            end
            prev_stall = w_m_tvalid && !m_tready;
            prev_data  = w_m_tdata[7:0];
         end
      end
   end

   // Called at a falling edge; returns at a later falling edge once the byte was accepted.
   task automatic send_byte(input logic [7:0] d, input logic last, input logic gap,
                            output int stalls);
      logic acc;
      stalls = 0;
      acc    = 1'b0;
      if (gap) begin
         s_tvalid = 1'b0;
         @(negedge clk);
      end
      s_tvalid = 1'b1;
      s_tdata  = d;
      s_tlast  = last;
      while (!acc && stalls <= 500) begin
         #2;
         if (w_s_tready) acc = 1'b1;
         else stalls++;
         @(negedge clk);
      end
      if (!acc) check("s_accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_beats(input int n);
      int t;
      t = 0;
      while (beat_q.size() < n && t < 500) begin
         @(negedge clk);
         #4;
         t++;
      end
      if (beat_q.size() < n) check("beat_timeout", 32'(beat_q.size()), 32'(n));
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int st;
      int stall_tot;
      @(negedge clk);
      sel = v.dut_b;
      beat_q.delete();
      cyc_q.delete();
      stall_tot = 0;
      for (int j = 0; j < v.n_in; j++) begin
         send_byte(v.din[j], (j == v.n_in - 1), 1'b0, st);
         stall_tot += st;
      end
      s_tvalid = 1'b0;
      wait_beats(v.n_out);
      @(negedge clk);
      #4;
      check({tag, "_frame_count"}, w_fc, 32'(v.fc));
      check({tag, "_beat_total"}, 32'(beat_q.size()), 32'(v.n_out));
      if (beat_q.size() == v.n_out) begin
         for (int j = 0; j < v.n_out; j++)
            check($sformatf("%s_beat%0d", tag, j), 32'(beat_q[j]), 32'(v.dout[j]));
         check({tag, "_back_to_back"}, 32'(cyc_q[v.n_out-1] - cyc_q[0]), 32'(v.n_out - 1));
      end
      check({tag, "_in_stalls"}, 32'(stall_tot), 32'(v.stalls));
   endtask

   vec_t vecs[8];

   initial begin
      int         st;
      int         t;
      int         len;
      logic [7:0] b;
      logic [7:0] sent_q[$];
      int         len_q[$];
      logic [7:0] buf_q[$];
      logic       in_esc;
      logic       ok;
      logic [7:0] cs;
      int         fidx;
      int         pos;

      //            din            n  dout                      n  stl fc  dut_b
      vecs[0] = '{32'h0102_0000, 2, 64'hC001_0203_C000_0000, 5, 2, 1, 1'b0};
      vecs[1] = '{32'hC0DB_0000, 2, 64'hC0DB_DCDB_DD1B_C000, 7, 3, 2, 1'b0};
      vecs[2] = '{32'hC000_0000, 2, 64'hC0DB_DC00_DBDC_C000, 7, 3, 3, 1'b0};
      vecs[3] = '{32'hDB00_0000, 1, 64'hC0DB_DDDB_DDC0_0000, 6, 2, 4, 1'b0};
      vecs[4] = '{32'h1122_4400, 3, 64'hC011_2244_77C0_0000, 6, 2, 5, 1'b0};
      vecs[5] = '{32'h5500_0000, 1, 64'h55C0_0000_0000_0000, 2, 1, 1, 1'b1};
      vecs[6] = '{32'hC000_0000, 1, 64'hDBDC_C000_0000_0000, 3, 1, 2, 1'b1};
      vecs[7] = '{32'h01DB_0200, 3, 64'h01DB_DD02_C000_0000, 5, 2, 3, 1'b1};

      rst_n    = 1'b0;
      s_tdata  = 8'h00;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      m_tready = 1'b1;
      sel      = 1'b0;
      rnd_mode = 1'b0;

      #12;
      check("rst_a_outputs", 32'({a_m_tvalid, a_s_tready, a_m_tdata}), 32'd0);
      check("rst_a_fc", a_fc, 32'd0);
      check("rst_b_outputs", 32'({b_m_tvalid, b_s_tready, b_m_tdata}), 32'd0);
      check("rst_b_fc", b_fc, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Random frames under 50% back-pressure, decoded and compared frame by frame.
      @(negedge clk);
      sel = 1'b0;
      beat_q.delete();
      cyc_q.delete();
      rnd_mode = 1'b1;
      for (int f = 0; f < 200; f++) begin
         len = $urandom_range(1, 6);
         len_q.push_back(len);
         for (int k = 0; k < len; k++) begin
            if ($urandom_range(0, 3) == 0) b = ($urandom_range(0, 1) == 1) ? 8'hC0 : 8'hDB;
            else b = 8'($urandom_range(0, 255));
            sent_q.push_back(b);
            send_byte(b, (k == len - 1), 1'($urandom_range(0, 3) == 0), st);
         end
         s_tvalid = 1'b0;
      end
      t = 0;
      while (a_fc != 32'd205 && t < 20000) begin
         @(negedge clk);
         t++;
      end
      check("rnd_frame_count", a_fc, 32'd205);
      rnd_mode = 1'b0;
      repeat (3) @(negedge clk);
      in_esc = 1'b0;
      fidx   = 0;
      pos    = 0;
      foreach (beat_q[i]) begin
         if (beat_q[i] == 8'hC0) begin
            if (buf_q.size() > 0) begin
               ok = 1'b0;
               if (fidx < len_q.size()) begin
                  len = len_q[fidx];
                  ok  = (buf_q.size() == len + 1);
                  cs  = 8'h00;
                  if (ok) begin
                     for (int k = 0; k < len; k++) begin
                        if (buf_q[k] !== sent_q[pos + k]) ok = 1'b0;
                        cs = cs ^ sent_q[pos + k];
                     end
                     if (buf_q[len] !== cs) ok = 1'b0;
                  end
                  pos += len;
               end
               check($sformatf("rnd_frame%0d", fidx), 32'(ok), 32'd1);
               fidx++;
               buf_q.delete();
            end
         end else if (in_esc) begin
            buf_q.push_back((beat_q[i] == 8'hDC) ? 8'hC0 : (beat_q[i] == 8'hDD) ? 8'hDB : 8'hFF);
            in_esc = 1'b0;
         end else if (beat_q[i] == 8'hDB) begin
            in_esc = 1'b1;
         end else begin
            buf_q.push_back(beat_q[i]);
         end
      end
      check("rnd_frames_decoded", 32'(fidx), 32'd200);

      // Reset in the middle of a payload, then a fresh single-byte frame.
      @(negedge clk);
      sel      = 1'b0;
      s_tvalid = 1'b1;
      s_tdata  = 8'h11;
      s_tlast  = 1'b0;
      repeat (4) @(negedge clk);
      s_tdata  = 8'h22;
      #1;
      rst_n    = 1'b0;
      s_tvalid = 1'b0;
      #2;
      check("midrst_outputs", 32'({a_m_tvalid, a_s_tready, a_m_tdata}), 32'd0);
      check("midrst_fc", a_fc, 32'd0);
      @(negedge clk);
      #2;
      check("midrst_hold_outputs", 32'({a_m_tvalid, a_s_tready, a_m_tdata}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      beat_q.delete();
      cyc_q.delete();
      send_byte(8'h10, 1'b1, 1'b0, st);
      s_tvalid = 1'b0;
      wait_beats(4);
      @(negedge clk);
      #4;
      check("postrst_fc", a_fc, 32'd1);
      check("postrst_beat_total", 32'(beat_q.size()), 32'd4);
      if (beat_q.size() == 4)
         check("postrst_beats", {beat_q[0], beat_q[1], beat_q[2], beat_q[3]}, 32'hC01010C0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
